// File: rtl/sram_axi_bridge_if.sv
// AXI3 master-side channel bundle for the sram-to-AXI bridge.
// Master drives the address/write channels and the ready signals of the response channels.
interface sram_axi_bridge_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;

   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;

   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;

   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/sram_axi_bridge.sv
// Bridges the core's inst/data sram-like ports onto one single-beat AXI3 master.
// One read and one write may be outstanding; the data port wins read arbitration.
module sram_axi_bridge #(
   parameter logic [3:0] INST_ID = 4'd0,
   parameter logic [3:0] DATA_ID = 4'd1
) (
   input  logic        clk,
   input  logic        resetn,

   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [31:0] inst_sram_addr,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,

   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [31:0] data_sram_addr,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,

   sram_axi_bridge_if.master axi
);

   typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_state_e;
   typedef enum logic [1:0] {WR_IDLE, WR_AW, WR_B} wr_state_e;

   rd_state_e   rd_state_q, rd_state_d;
   logic [31:0] rd_addr_q, rd_addr_d;
   logic [1:0]  rd_size_q, rd_size_d;
   logic [3:0]  rd_id_q, rd_id_d;
   logic        rd_is_data_q, rd_is_data_d;

   wr_state_e   wr_state_q, wr_state_d;
   logic [31:0] wr_addr_q, wr_addr_d;
   logic [1:0]  wr_size_q, wr_size_d;
   logic [3:0]  wr_strb_q, wr_strb_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;

   logic data_rd_acc, inst_rd_acc, data_wr_acc;
   logic r_fire, b_fire;
   logic aw_ok, w_ok;

   always_comb begin
      rd_state_d   = rd_state_q;
      rd_addr_d    = rd_addr_q;
      rd_size_d    = rd_size_q;
      rd_id_d      = rd_id_q;
      rd_is_data_d = rd_is_data_q;
      wr_state_d   = wr_state_q;
      wr_addr_d    = wr_addr_q;
      wr_size_d    = wr_size_q;
      wr_strb_d    = wr_strb_q;
      wr_data_d    = wr_data_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;

      // Data reads wait for the write FSM to drain so a read never overtakes a pending store.
      data_rd_acc = (rd_state_q == RD_IDLE) && data_sram_req && !data_sram_wr
                    && (wr_state_q == WR_IDLE);
      inst_rd_acc = (rd_state_q == RD_IDLE) && inst_sram_req && !data_rd_acc;
      data_wr_acc = data_sram_req && data_sram_wr && (wr_state_q == WR_IDLE)
                    && !(rd_is_data_q && (rd_state_q != RD_IDLE));

      r_fire = (rd_state_q == RD_R) && axi.rvalid;
      b_fire = (wr_state_q == WR_B) && axi.bvalid;
      aw_ok  = aw_done_q || axi.awready;
      w_ok   = w_done_q  || axi.wready;

      case (rd_state_q)
         RD_IDLE: begin
            if (data_rd_acc) begin
               rd_state_d   = RD_AR;
               rd_addr_d    = data_sram_addr;
               rd_size_d    = data_sram_size;
               rd_id_d      = DATA_ID;
               rd_is_data_d = 1'b1;
            end else if (inst_rd_acc) begin
               rd_state_d   = RD_AR;
               rd_addr_d    = inst_sram_addr;
               rd_size_d    = inst_sram_size;
               rd_id_d      = INST_ID;
               rd_is_data_d = 1'b0;
            end
         end
         RD_AR:   if (axi.arready) rd_state_d = RD_R;
         RD_R:    if (axi.rvalid)  rd_state_d = RD_IDLE;
         default: rd_state_d = RD_IDLE;
      endcase

      case (wr_state_q)
         WR_IDLE: begin
            if (data_wr_acc) begin
               wr_state_d = WR_AW;
               wr_addr_d  = data_sram_addr;
               wr_size_d  = data_sram_size;
               wr_strb_d  = data_sram_wstrb;
               wr_data_d  = data_sram_wdata;
               aw_done_d  = 1'b0;
               w_done_d   = 1'b0;
            end
         end
         WR_AW: begin
            aw_done_d = aw_ok;
            w_done_d  = w_ok;
            if (aw_ok && w_ok) wr_state_d = WR_B;
         end
         WR_B:    if (axi.bvalid) wr_state_d = WR_IDLE;
         default: wr_state_d = WR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_state_q   <= RD_IDLE;
         rd_addr_q    <= '0;
         rd_size_q    <= '0;
         rd_id_q      <= '0;
         rd_is_data_q <= 1'b0;
         wr_state_q   <= WR_IDLE;
         wr_addr_q    <= '0;
         wr_size_q    <= '0;
         wr_strb_q    <= '0;
         wr_data_q    <= '0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
      end else begin
         rd_state_q   <= rd_state_d;
         rd_addr_q    <= rd_addr_d;
         rd_size_q    <= rd_size_d;
         rd_id_q      <= rd_id_d;
         rd_is_data_q <= rd_is_data_d;
         wr_state_q   <= wr_state_d;
         wr_addr_q    <= wr_addr_d;
         wr_size_q    <= wr_size_d;
         wr_strb_q    <= wr_strb_d;
         wr_data_q    <= wr_data_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
      end
   end

   assign inst_sram_addr_ok = inst_rd_acc;
   assign data_sram_addr_ok = data_rd_acc || data_wr_acc;
   assign inst_sram_data_ok = r_fire && (axi.rid == INST_ID);
   assign data_sram_data_ok = (r_fire && (axi.rid == DATA_ID)) || b_fire;
   assign inst_sram_rdata   = axi.rdata;
   assign data_sram_rdata   = axi.rdata;

   assign axi.arid    = rd_id_q;
   assign axi.araddr  = rd_addr_q;
   assign axi.arlen   = '0;
   assign axi.arsize  = {1'b0, rd_size_q};
   assign axi.arburst = 2'b01;
   assign axi.arlock  = '0;
   assign axi.arcache = '0;
   assign axi.arprot  = '0;
   assign axi.arvalid = (rd_state_q == RD_AR);
   assign axi.rready  = (rd_state_q == RD_R);

   assign axi.awid    = DATA_ID;
   assign axi.awaddr  = wr_addr_q;
   assign axi.awlen   = '0;
   assign axi.awsize  = {1'b0, wr_size_q};
   assign axi.awburst = 2'b01;
   assign axi.awlock  = '0;
   assign axi.awcache = '0;
   assign axi.awprot  = '0;
   assign axi.awvalid = (wr_state_q == WR_AW) && !aw_done_q;

   assign axi.wid     = DATA_ID;
   assign axi.wdata   = wr_data_q;
   assign axi.wstrb   = wr_strb_q;
   assign axi.wlast   = 1'b1;
   assign axi.wvalid  = (wr_state_q == WR_AW) && !w_done_q;
   assign axi.bready  = (wr_state_q == WR_B);

   logic unused_inputs;
   assign unused_inputs = ^{inst_sram_wr, axi.rresp, axi.rlast, axi.bid, axi.bresp};

endmodule
